// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// Package : decode_pkg
// Brief   : Opcodes, control-field encodings and shared types for the decode stage.
// Rev     : 1.0 - initial release
// ============================================================================
package decode_pkg;

    localparam logic [6:0] c_opc_load     = 7'b0000011;
    localparam logic [6:0] c_opc_misc_mem = 7'b0001111;
    localparam logic [6:0] c_opc_op_imm   = 7'b0010011;
    localparam logic [6:0] c_opc_auipc    = 7'b0010111;
    localparam logic [6:0] c_opc_store    = 7'b0100011;
    localparam logic [6:0] c_opc_op       = 7'b0110011;
    localparam logic [6:0] c_opc_lui      = 7'b0110111;
    localparam logic [6:0] c_opc_branch   = 7'b1100011;
    localparam logic [6:0] c_opc_jalr     = 7'b1100111;
    localparam logic [6:0] c_opc_jal      = 7'b1101111;
    localparam logic [6:0] c_opc_system   = 7'b1110011;

    localparam logic [31:0] c_instr_ecall  = 32'h0000_0073;
    localparam logic [31:0] c_instr_ebreak = 32'h0010_0073;

    localparam logic [2:0] c_imm_i = 3'b000;
    localparam logic [2:0] c_imm_s = 3'b001;
    localparam logic [2:0] c_imm_u = 3'b010;
    localparam logic [2:0] c_imm_j = 3'b100;
    localparam logic [2:0] c_imm_b = 3'b101;

    localparam logic [1:0] c_src_rr = 2'b00;
    localparam logic [1:0] c_src_ri = 2'b10;
    localparam logic [1:0] c_src_pi = 2'b11;

    localparam logic [1:0] c_exec_alsu   = 2'b00;
    localparam logic [1:0] c_exec_imm    = 2'b01;
    localparam logic [1:0] c_exec_pc4    = 2'b10;
    localparam logic [1:0] c_exec_muldiv = 2'b11;

    localparam logic [2:0] c_flow_none = 3'b000;
    localparam logic [2:0] c_flow_je   = 3'b100;
    localparam logic [2:0] c_flow_bz   = 3'b010;
    localparam logic [2:0] c_flow_bnz  = 3'b011;

    localparam logic [3:0] c_alsu_add  = 4'b0000;
    localparam logic [3:0] c_alsu_sub  = 4'b1000;
    localparam logic [3:0] c_alsu_slt  = 4'b0010;
    localparam logic [3:0] c_alsu_sltu = 4'b0011;

    typedef enum logic [1:0] {
        CAUSE_ILLEGAL = 2'd0,
        CAUSE_ECALL   = 2'd1,
        CAUSE_EBREAK  = 2'd2
    } cause_e;

    typedef enum logic [1:0] {
        KIND_NORMAL = 2'd0,
        KIND_FENCE  = 2'd1,
        KIND_TRAP   = 2'd2
    } kind_e;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_FENCE_WAIT = 2'd1,
        ST_TRAP_WAIT  = 2'd2
    } state_e;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [1:0] rs_valid;
        logic       rd_valid;
        logic [2:0] imm_sel;
        logic [1:0] src_sel;
        logic [3:0] alsu_func;
        logic [1:0] exec_sel;
        logic [2:0] muldiv_func;
        logic       jump_d;
        logic [2:0] flow_ctrl;
        logic       mem_write;
        logic       mem_read;
        logic [2:0] mem_size;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/decode_logic.sv
`default_nettype none
// ============================================================================
// Module : decode_logic
// Brief  : Combinational RV32I(+M) decoder with full illegal-instruction detection.
// Rev    : 1.0 - initial release
// ============================================================================
module decode_logic
    import decode_pkg::*;
#(
    parameter bit EN_M = 1'b0
) (
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output kind_e       kind,
    output cause_e      cause
);

    logic [6:0] w_opcode;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_illegal;

    assign w_opcode = instr[6:0];
    assign w_f3     = instr[14:12];
    assign w_f7     = instr[31:25];

    always_comb begin
        ctrl      = '0;
        ctrl.rs1  = instr[19:15];
        ctrl.rs2  = instr[24:20];
        ctrl.rd   = instr[11:7];
        kind      = KIND_NORMAL;
        cause     = CAUSE_ILLEGAL;
        w_illegal = 1'b0;
        case (w_opcode)
            c_opc_op_imm: begin
                ctrl.rs_valid  = 2'b01;
                ctrl.rd_valid  = 1'b1;
                ctrl.imm_sel   = c_imm_i;
                ctrl.src_sel   = c_src_ri;
                ctrl.alsu_func = {1'b0, w_f3};
                // Shifts carry the arithmetic/logical selector in funct7[5].
                if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
                    ctrl.alsu_func = {w_f7[5], w_f3};
                    w_illegal = !(w_f7 == 7'b0000000 ||
                                  (w_f3 == 3'b101 && w_f7 == 7'b0100000));
                end
            end
            c_opc_op: begin
                ctrl.rs_valid = 2'b11;
                ctrl.rd_valid = 1'b1;
                ctrl.src_sel  = c_src_rr;
                if (w_f7 == 7'b0000001) begin
                    if (EN_M) begin
                        ctrl.exec_sel    = c_exec_muldiv;
                        ctrl.muldiv_func = w_f3;
                    end else begin
                        w_illegal = 1'b1;
                    end
                end else begin
                    ctrl.alsu_func = {w_f7[5], w_f3};
                    w_illegal = !(w_f7 == 7'b0000000 ||
                                  (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101)));
                end
            end
            c_opc_lui: begin
                ctrl.rd_valid = 1'b1;
                ctrl.imm_sel  = c_imm_u;
                ctrl.exec_sel = c_exec_imm;
            end
            c_opc_auipc: begin
                ctrl.rd_valid  = 1'b1;
                ctrl.imm_sel   = c_imm_u;
                ctrl.src_sel   = c_src_pi;
                ctrl.alsu_func = c_alsu_add;
            end
            c_opc_load: begin
                ctrl.rs_valid  = 2'b01;
                ctrl.rd_valid  = 1'b1;
                ctrl.imm_sel   = c_imm_i;
                ctrl.src_sel   = c_src_ri;
                ctrl.alsu_func = c_alsu_add;
                ctrl.mem_read  = 1'b1;
                ctrl.mem_size  = w_f3;
                w_illegal = (w_f3 == 3'b011 || w_f3 == 3'b110 || w_f3 == 3'b111);
            end
            c_opc_store: begin
                ctrl.rs_valid  = 2'b11;
                ctrl.imm_sel   = c_imm_s;
                ctrl.src_sel   = c_src_ri;
                ctrl.alsu_func = c_alsu_add;
                ctrl.mem_write = 1'b1;
                ctrl.mem_size  = w_f3;
                w_illegal = (w_f3 >= 3'b011);
            end
            c_opc_jal: begin
                ctrl.rd_valid = 1'b1;
                ctrl.imm_sel  = c_imm_j;
                ctrl.exec_sel = c_exec_pc4;
                ctrl.jump_d   = 1'b1;
            end
            c_opc_jalr: begin
                ctrl.rs_valid  = 2'b01;
                ctrl.rd_valid  = 1'b1;
                ctrl.imm_sel   = c_imm_i;
                ctrl.src_sel   = c_src_ri;
                ctrl.alsu_func = c_alsu_add;
                ctrl.exec_sel  = c_exec_pc4;
                ctrl.flow_ctrl = c_flow_je;
                w_illegal = (w_f3 != 3'b000);
            end
            c_opc_branch: begin
                ctrl.rs_valid = 2'b11;
                ctrl.imm_sel  = c_imm_b;
                ctrl.src_sel  = c_src_rr;
                case (w_f3)
                    3'b000:  begin ctrl.alsu_func = c_alsu_sub;  ctrl.flow_ctrl = c_flow_bz;  end
                    3'b001:  begin ctrl.alsu_func = c_alsu_sub;  ctrl.flow_ctrl = c_flow_bnz; end
                    3'b100:  begin ctrl.alsu_func = c_alsu_slt;  ctrl.flow_ctrl = c_flow_bnz; end
                    3'b101:  begin ctrl.alsu_func = c_alsu_slt;  ctrl.flow_ctrl = c_flow_bz;  end
                    3'b110:  begin ctrl.alsu_func = c_alsu_sltu; ctrl.flow_ctrl = c_flow_bnz; end
                    3'b111:  begin ctrl.alsu_func = c_alsu_sltu; ctrl.flow_ctrl = c_flow_bz;  end
                    default: w_illegal = 1'b1;
                endcase
            end
            c_opc_misc_mem: kind = KIND_FENCE;
            c_opc_system: begin
                // No Zicsr: only the two exact environment-call words are recognised.
                if (instr == c_instr_ecall) begin
                    kind  = KIND_TRAP;
                    cause = CAUSE_ECALL;
                end else if (instr == c_instr_ebreak) begin
                    kind  = KIND_TRAP;
                    cause = CAUSE_EBREAK;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            default: w_illegal = 1'b1;
        endcase
        if (w_illegal) begin
            kind  = KIND_TRAP;
            cause = CAUSE_ILLEGAL;
        end
    end

endmodule
`default_nettype wire

// File: rtl/decode_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module : decode_stage_ctrl
// Brief  : Registered decode stage with D/E handshake, FENCE drain and trap FSM.
// Rev    : 1.0 - initial release
// ============================================================================
module decode_stage_ctrl
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter bit EN_M = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            d_valid,
    output logic            d_ready,
    input  logic [31:0]     d_instr,
    input  logic [XLEN-1:0] d_pc,
    output logic            e_valid,
    input  logic            e_ready,
    output logic [XLEN-1:0] e_pc,
    output logic [4:0]      e_rs1,
    output logic [4:0]      e_rs2,
    output logic [4:0]      e_rd,
    output logic [1:0]      e_rs_valid,
    output logic            e_rd_valid,
    output logic [2:0]      e_imm_sel,
    output logic [1:0]      e_src_sel,
    output logic [3:0]      e_alsu_func,
    output logic [1:0]      e_exec_sel,
    output logic [2:0]      e_muldiv_func,
    output logic            e_jump_d,
    output logic [2:0]      e_flow_ctrl,
    output logic            e_mem_write,
    output logic            e_mem_read,
    output logic [2:0]      e_mem_size,
    output logic            trap,
    output logic [1:0]      trap_cause,
    input  logic            flush,
    input  logic            mem_idle
);

    ctrl_t           w_ctrl;
    kind_e           w_kind;
    cause_e          w_cause;
    logic            w_accept;

    state_e          r_state;
    ctrl_t           r_ctrl;
    logic [XLEN-1:0] r_pc;
    logic            r_e_valid;
    logic            r_trap;
    cause_e          r_cause;

    decode_logic #(
        .EN_M (EN_M)
    ) u_decode_logic (
        .instr (d_instr),
        .ctrl  (w_ctrl),
        .kind  (w_kind),
        .cause (w_cause)
    );

    assign d_ready  = (r_state == ST_RUN) && !flush && (!r_e_valid || e_ready);
    assign w_accept = d_valid && d_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_RUN;
            r_ctrl    <= '0;
            r_pc      <= '0;
            r_e_valid <= 1'b0;
            r_trap    <= 1'b0;
            r_cause   <= CAUSE_ILLEGAL;
        end else begin
            r_trap <= 1'b0;
            if (flush) begin
                r_e_valid <= 1'b0;
                r_state   <= ST_RUN;
            end else begin
                if (w_accept && w_kind == KIND_NORMAL) begin
                    r_ctrl    <= w_ctrl;
                    r_pc      <= d_pc;
                    r_e_valid <= 1'b1;
                end else if (r_e_valid && e_ready) begin
                    r_e_valid <= 1'b0;
                end
                case (r_state)
                    ST_RUN: begin
                        if (w_accept && w_kind == KIND_FENCE) begin
                            r_state <= ST_FENCE_WAIT;
                        end else if (w_accept && w_kind == KIND_TRAP) begin
                            r_trap  <= 1'b1;
                            r_cause <= w_cause;
                            r_state <= ST_TRAP_WAIT;
                        end
                    end
                    // Drain completes only once execute is empty and memory is quiet.
                    ST_FENCE_WAIT: begin
                        if (mem_idle && !r_e_valid) begin
                            r_state <= ST_RUN;
                        end
                    end
                    ST_TRAP_WAIT: begin
                        r_state <= ST_TRAP_WAIT;
                    end
                    default: r_state <= ST_RUN;
                endcase
            end
        end
    end

    assign e_valid       = r_e_valid;
    assign e_pc          = r_pc;
    assign e_rs1         = r_ctrl.rs1;
    assign e_rs2         = r_ctrl.rs2;
    assign e_rd          = r_ctrl.rd;
    assign e_rs_valid    = r_ctrl.rs_valid;
    assign e_rd_valid    = r_ctrl.rd_valid;
    assign e_imm_sel     = r_ctrl.imm_sel;
    assign e_src_sel     = r_ctrl.src_sel;
    assign e_alsu_func   = r_ctrl.alsu_func;
    assign e_exec_sel    = r_ctrl.exec_sel;
    assign e_muldiv_func = r_ctrl.muldiv_func;
    assign e_jump_d      = r_ctrl.jump_d;
    assign e_flow_ctrl   = r_ctrl.flow_ctrl;
    assign e_mem_write   = r_ctrl.mem_write;
    assign e_mem_read    = r_ctrl.mem_read;
    assign e_mem_size    = r_ctrl.mem_size;
    assign trap          = r_trap;
    assign trap_cause    = r_cause;

endmodule
`default_nettype wire
